// File: rtl/mc_control_fsm.sv
// Main control FSM for the multicycle datapath: one step per clock through
// fetch/decode/execute/memory/writeback, driving every datapath strobe.
module mc_control_fsm #(
  parameter int                    OPCODE_W = 4,
  parameter logic [OPCODE_W-1:0]   OP_RTYPE = 4'b0000,
  parameter logic [OPCODE_W-1:0]   OP_ADDI  = 4'b0001,
  parameter logic [OPCODE_W-1:0]   OP_LW    = 4'b0010,
  parameter logic [OPCODE_W-1:0]   OP_SW    = 4'b0011,
  parameter logic [OPCODE_W-1:0]   OP_BEQ   = 4'b0100,
  parameter logic [OPCODE_W-1:0]   OP_J     = 4'b0101,
  parameter logic [OPCODE_W-1:0]   OP_HALT  = 4'b1111
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_en,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                halted,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_ALU_WB_R = 4'd9,
    S_ALU_WB_I = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  state_t cur, nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  assign state = cur;

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if      (opcode == OP_RTYPE)                    nxt = S_EXEC_R;
        else if (opcode == OP_ADDI)                     nxt = S_EXEC_I;
        else if (opcode == OP_LW || opcode == OP_SW)    nxt = S_MEM_ADDR;
        else if (opcode == OP_BEQ)                      nxt = S_BRANCH;
        else if (opcode == OP_J)                        nxt = S_JUMP;
        else if (opcode == OP_HALT)                     nxt = S_HALT;
        else                                            nxt = S_FETCH;
      end
      // IR is stable, so re-sampling opcode gives the DECODE-time answer
      S_MEM_ADDR: nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   nxt = S_FETCH;
      S_MEM_WR:   nxt = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   nxt = S_ALU_WB_R;
      S_EXEC_I:   nxt = S_ALU_WB_I;
      S_ALU_WB_R: nxt = S_FETCH;
      S_ALU_WB_I: nxt = S_FETCH;
      S_BRANCH:   nxt = S_FETCH;
      S_JUMP:     nxt = S_FETCH;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_en     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    halted        = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR load and PC+1 commit only in the cycle the fetch completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ALU_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ALU_WB_I: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        branch_en     = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: driver pushes the expected state and
// control word for each cycle, a negedge monitor pops and compares.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_en, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a, halted;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctrl;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_en(branch_en),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .halted(halted), .state(state)
  );

  // {pc_write, pc_write_cond, branch_en, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, halted}
  logic [17:0] act;
  assign act = {pc_write, pc_write_cond, branch_en, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b,
                alu_op, pc_source, halted};

  function automatic logic [17:0] exp_ctrl(input logic [3:0] s, input logic mr);
    case (s)
      4'd1:  return mr ? 18'b1_0_0_0_1_0_1_0_0_0_0_01_00_00_0
                       : 18'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0;
      4'd2:  return 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0;
      4'd3:  return 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
      4'd4:  return 18'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0;
      4'd5:  return 18'b0_0_0_0_0_0_0_1_1_0_0_00_00_00_0;
      4'd6:  return 18'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0;
      4'd7:  return 18'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0;
      4'd8:  return 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
      4'd9:  return 18'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0;
      4'd10: return 18'b0_0_0_0_0_0_0_0_1_0_0_00_00_00_0;
      4'd11: return 18'b0_1_1_0_0_0_0_0_0_0_1_00_01_01_0;
      4'd12: return 18'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_0;
      4'd13: return 18'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_1;
      default: return 18'b0;
    endcase
  endfunction

  // Driver: called at posedge+1; sets inputs for this cycle and predicts the outputs
  task automatic cyc(input logic [3:0] op, input logic mr, input logic [3:0] exp_st);
    exp_t e;
    opcode    = op;
    mem_ready = mr;
    e.st   = exp_st;
    e.ctrl = exp_ctrl(exp_st, mr);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if (state !== 4'd0 || act !== 18'b0) begin
      errors++;
      $display("FAIL %s: state=%0d ctrl=%b, required state=0 ctrl=0", name, state, act);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (state !== e.st || act !== e.ctrl) begin
        errors++;
        $display("FAIL seq t=%0t: state=%0d ctrl=%b, required state=%0d ctrl=%b",
                 $time, state, act, e.st, e.ctrl);
      end
      checks++;
      if (branch_en !== (state == 4'd11)) begin
        errors++;
        $display("FAIL branch_en_only_in_branch: state=%0d branch_en=%b", state, branch_en);
      end
      checks++;
      if (pc_write === 1'b1 && pc_write_cond === 1'b1) begin
        errors++;
        $display("FAIL pc_write_exclusive: pc_write=%b pc_write_cond=%b, required not both 1",
                 pc_write, pc_write_cond);
      end
    end
  end

  initial begin
    rst = 1'b1; opcode = 4'd0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    rst = 1'b0;
    cyc(4'd0, 1'b1, 4'd0);
    // R-type
    cyc(4'd0, 1'b1, 4'd1); cyc(4'd0, 1'b1, 4'd2);
    cyc(4'd0, 1'b1, 4'd7); cyc(4'd0, 1'b1, 4'd9);
    // ADDI
    cyc(4'd1, 1'b1, 4'd1); cyc(4'd1, 1'b1, 4'd2);
    cyc(4'd1, 1'b1, 4'd8); cyc(4'd1, 1'b1, 4'd10);
    // LW with two MEM_RD stall cycles
    cyc(4'd2, 1'b1, 4'd1); cyc(4'd2, 1'b1, 4'd2); cyc(4'd2, 1'b1, 4'd3);
    cyc(4'd2, 1'b0, 4'd4); cyc(4'd2, 1'b0, 4'd4); cyc(4'd2, 1'b1, 4'd4);
    cyc(4'd2, 1'b1, 4'd5);
    // SW with one FETCH stall and one MEM_WR stall
    cyc(4'd3, 1'b0, 4'd1); cyc(4'd3, 1'b1, 4'd1); cyc(4'd3, 1'b1, 4'd2);
    cyc(4'd3, 1'b1, 4'd3); cyc(4'd3, 1'b0, 4'd6); cyc(4'd3, 1'b1, 4'd6);
    // BEQ
    cyc(4'd4, 1'b1, 4'd1); cyc(4'd4, 1'b1, 4'd2); cyc(4'd4, 1'b1, 4'd11);
    // J
    cyc(4'd5, 1'b1, 4'd1); cyc(4'd5, 1'b1, 4'd2); cyc(4'd5, 1'b1, 4'd12);
    // illegal opcode acts as NOP
    cyc(4'd7, 1'b1, 4'd1); cyc(4'd7, 1'b1, 4'd2);
    // HALT holds until reset
    cyc(4'd15, 1'b1, 4'd1); cyc(4'd15, 1'b1, 4'd2);
    for (int i = 0; i < 22; i++) cyc(4'd15, 1'b1, 4'd13);
    #2 rst = 1'b1;
    #1 chk_zero("reset_from_halt");
    @(posedge clk); #1 rst = 1'b0;
    // async reset in the middle of EXEC_R
    cyc(4'd0, 1'b1, 4'd0); cyc(4'd0, 1'b1, 4'd1); cyc(4'd0, 1'b1, 4'd2);
    checks++;
    if (state !== 4'd7) begin
      errors++;
      $display("FAIL reach_exec_r: state=%0d, required 7", state);
    end
    #2 rst = 1'b1;
    #1 chk_zero("async_reset_exec_r");
    @(posedge clk); #1 rst = 1'b0;
    cyc(4'd0, 1'b1, 4'd0); cyc(4'd0, 1'b0, 4'd1); cyc(4'd0, 1'b1, 4'd1);
    // async reset during a MEM_RD stall
    cyc(4'd2, 1'b1, 4'd2); cyc(4'd2, 1'b1, 4'd3); cyc(4'd2, 1'b0, 4'd4);
    #2 rst = 1'b1;
    #1 chk_zero("async_reset_mem_stall");
    @(posedge clk); #1 rst = 1'b0;
    cyc(4'd0, 1'b1, 4'd0); cyc(4'd0, 1'b1, 4'd1);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
